// File: rtl/alu_pg_if.sv
// alu_pg_if: request/response bundle between issue logic and the power-gated ALU
interface alu_pg_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready;
  logic [3:0] opcode;
  logic [WIDTH-1:0] A, B;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] result, result_hi;
  logic flag_zero, flag_carry, flag_ovf, flag_dz, flag_abort, busy;
  modport master(
    output in_valid, opcode, A, B, out_ready,
    input in_ready, out_valid, result, result_hi, flag_zero, flag_carry, flag_ovf, flag_dz, flag_abort, busy
  );
  modport slave(
    input in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, result, result_hi, flag_zero, flag_carry, flag_ovf, flag_dz, flag_abort, busy
  );
endinterface

// File: rtl/alu_pg_seq.sv
// alu_pg_seq: power-gated ALU with multi-cycle multiply, restoring divide and clamped outputs
module alu_pg_seq #(
  parameter int WIDTH = 16,
  parameter int MUL_CYCLES = 5
) (
  input logic clk,
  input logic rst,
  input logic alu_pwr_en,
  input logic iso_en,
  alu_pg_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CW = $clog2((MUL_CYCLES > WIDTH ? MUL_CYCLES : WIDTH) + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] h;
    logic z, c, v, d;
  } res_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, rem_r;
  res_t res_r;
  logic out_v, abort_r, act;
  logic [WIDTH:0] rem_sh, rem_df;
  logic [WIDTH-1:0] rem_nx, q_nx;
  logic take;
  function automatic res_t calc(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic [2*WIDTH-1:0] p;
    res_t o;
    s = (op == 4'h1) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    o = '0;
    case (op)
      4'h0: begin o.r = s[WIDTH-1:0]; o.c = s[WIDTH]; o.v = (a[WIDTH-1] == b[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]); end
      4'h1: begin o.r = s[WIDTH-1:0]; o.c = s[WIDTH]; o.v = (a[WIDTH-1] != b[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]); end
      4'h2: o.r = a & b;
      4'h3: o.r = a | b;
      4'h4: o.r = a ^ b;
      4'h5: o.r = ~(a | b);
      4'h6: o.r = a << b[SHAMT_W-1:0];
      4'h7: o.r = ~(a ^ b);
      4'h8: begin {o.h, o.r} = p; o.v = |p[2*WIDTH-1:WIDTH]; end
      4'h9: begin o.r = '1; o.h = a; o.d = 1'b1; end
      4'hA: o.r = a >> b[SHAMT_W-1:0];
      4'hB: o.r = $signed(a) >>> b[SHAMT_W-1:0];
      default: o = '0;
    endcase
    o.z = (op < 4'hC) & (o.r == '0);
    return o;
  endfunction
  assign act = alu_pwr_en & ~iso_en;
  // a_r doubles as the quotient shift register during divide
  assign rem_sh = {rem_r, a_r[WIDTH-1]};
  assign rem_df = rem_sh - {1'b0, b_r};
  assign take = ~rem_df[WIDTH];
  assign rem_nx = take ? rem_df[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_nx = {a_r[WIDTH-2:0], take};
  assign bus.in_ready = act & (state == IDLE);
  assign bus.out_valid = act & out_v;
  assign bus.result = act ? res_r.r : '0;
  assign bus.result_hi = act ? res_r.h : '0;
  assign bus.flag_zero = act & res_r.z;
  assign bus.flag_carry = act & res_r.c;
  assign bus.flag_ovf = act & res_r.v;
  assign bus.flag_dz = act & res_r.d;
  assign bus.flag_abort = abort_r;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_v <= 1'b0;
      abort_r <= 1'b0;
      res_r <= '0;
      a_r <= '0;
      b_r <= '0;
      rem_r <= '0;
    end else if (!act) begin
      if (state != IDLE) begin
        state <= IDLE;
        cnt <= '0;
        out_v <= 1'b0;
        abort_r <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          abort_r <= 1'b0;
          a_r <= bus.A;
          b_r <= bus.B;
          rem_r <= '0;
          cnt <= '0;
          if (bus.opcode == 4'h8 && MUL_CYCLES > 1) state <= MUL;
          else if (bus.opcode == 4'h9 && bus.B != '0) state <= DIV;
          else begin
            res_r <= calc(bus.opcode, bus.A, bus.B);
            out_v <= 1'b1;
            state <= DONE;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYCLES - 1)) begin
            res_r <= calc(4'h8, a_r, b_r);
            out_v <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          a_r <= q_nx;
          rem_r <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            res_r <= '{r: q_nx, h: rem_nx, z: ~|q_nx, c: 1'b0, v: 1'b0, d: 1'b0};
            out_v <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_v <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pg_seq.sv
// tb_alu_pg_seq: scoreboard bench with an arithmetic reference model for alu_pg_seq
module tb_alu_pg_seq;
  localparam int W = 16;
  logic clk = 0, rst = 1, alu_pwr_en = 1, iso_en = 0;
  int total = 0, bad = 0, cyc = 0, issued = 0, done_cnt = 0;
  bit hold = 0, bp_mode = 0, seen = 0;
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] h;
    logic z, c, v, d;
    int lat;
    int k;
  } exp_t;
  exp_t q[$];
  alu_pg_if #(.WIDTH(W)) bus();
  alu_pg_seq #(.WIDTH(W), .MUL_CYCLES(5)) dut(.clk(clk), .rst(rst), .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ~hold;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act_v, exp_v);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ua, ub, sa, sb, s, sr;
    longint p;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    e = '0;
    case (op)
      4'h0: begin s = ua + ub; sr = sa + sb; e.r = s[15:0]; e.c = s > 65535; e.v = sr > 32767 || sr < -32768; end
      4'h1: begin s = ua - ub; sr = sa - sb; e.r = s[15:0]; e.c = ua < ub; e.v = sr > 32767 || sr < -32768; end
      4'h2: e.r = a & b;
      4'h3: e.r = a | b;
      4'h4: e.r = a ^ b;
      4'h5: e.r = ~(a | b);
      4'h6: e.r = a << b[3:0];
      4'h7: e.r = ~(a ^ b);
      4'h8: begin p = longint'(ua) * longint'(ub); e.r = p[15:0]; e.h = p[31:16]; e.v = e.h != 0; e.lat = 5; end
      4'h9: if (ub == 0) begin e.r = 16'hFFFF; e.h = a; e.d = 1; end
            else begin s = ua / ub; sr = ua % ub; e.r = s[15:0]; e.h = sr[15:0]; e.lat = 16; end
      4'hA: e.r = a >> b[3:0];
      4'hB: begin s = sa >>> b[3:0]; e.r = s[15:0]; end
      default: e.r = 0;
    endcase
    e.z = (op < 4'hC) && (e.r == 0);
    return e;
  endfunction
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
    chk("in_ready_before_issue", bus.in_ready, 1);
    bus.in_valid = 1; bus.opcode = op; bus.A = a; bus.B = b;
    if (push) begin
      e = model(op, a, b);
      e.k = cyc + 1;
      q.push_back(e);
      issued++;
    end
    @(negedge clk);
    bus.in_valid = 0; bus.opcode = 0; bus.A = 0; bus.B = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done_cnt != issued && n < 300) begin
      chk("busy_while_pending", {bus.in_ready, bus.busy}, 2'b01);
      @(negedge clk);
      n++;
    end
    if (done_cnt != issued) chk("response_timeout", done_cnt, issued);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        if (!seen) begin chk("latency", cyc - q[0].k, q[0].lat); seen = 1; end
        chk("result", bus.result, q[0].r);
        chk("result_hi", bus.result_hi, q[0].h);
        chk("flags_zcvd", {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz}, {q[0].z, q[0].c, q[0].v, q[0].d});
        if (bus.out_ready) begin void'(q.pop_front()); seen = 0; done_cnt++; end
      end
    end
  end
  initial begin
    bus.in_valid = 0; bus.opcode = 0; bus.A = 0; bus.B = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.out_valid, bus.result, bus.result_hi, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz, bus.flag_abort, bus.busy}, 0);
    rst = 0;
    issue(4'h0, 16'hFFFF, 16'h0001, 1); wait_done();
    issue(4'h1, 16'h8000, 16'h0001, 1); wait_done();
    issue(4'h8, 16'h1234, 16'h0100, 1); wait_done();
    issue(4'h9, 16'd1000, 16'd7, 1); wait_done();
    issue(4'h9, 16'h00AB, 16'h0000, 1); wait_done();
    issue(4'hD, 16'h1234, 16'h5678, 1); wait_done();
    hold = 1;
    issue(4'h0, 16'h1111, 16'h2222, 1);
    repeat (3) begin chk("bp_hold", {bus.out_valid, bus.in_ready}, 2'b10); @(negedge clk); end
    hold = 0;
    wait_done();
    issue(4'h4, 16'hA5A5, 16'h0FF0, 1); wait_done();
    issue(4'h9, 16'd1000, 16'd7, 0);
    repeat (4) @(negedge clk);
    iso_en = 1;
    #1;
    chk("iso_clamp", {bus.in_ready, bus.out_valid, bus.result, bus.result_hi, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz}, 0);
    chk("iso_busy_same_cycle", bus.busy, 1);
    @(negedge clk);
    chk("iso_abort", {bus.busy, bus.flag_abort}, 2'b01);
    iso_en = 0;
    issue(4'h3, 16'h00F0, 16'h000F, 1);
    chk("abort_cleared", bus.flag_abort, 0);
    wait_done();
    bus.in_valid = 1; bus.opcode = 4'h0; iso_en = 1;
    @(negedge clk);
    chk("no_accept_under_iso", bus.busy, 0);
    bus.in_valid = 0; iso_en = 0;
    @(negedge clk);
    chk("still_idle", bus.busy, 0);
    issue(4'h8, 16'h1234, 16'h0100, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("reset_mid_mul", {bus.out_valid, bus.result, bus.result_hi, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz, bus.flag_abort, bus.busy}, 0);
    rst = 0;
    issue(4'hB, 16'h8000, 16'h0004, 1); wait_done();
    bp_mode = 1;
    repeat (40) begin
      logic [3:0] op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      issue(op, a, b, 1);
      wait_done();
    end
    bp_mode = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_pg_seq.md
Name: alu_pg_seq

Overview:
- Next-generation power-gated ALU: width-parametrised datapath with a valid/ready handshake on both input and output.
- Operands are captured at accept, so input buses are free immediately after the handshake.
- Multiply is multi-cycle with full double-width product; divide is iterative restoring with quotient and remainder.
- Outputs status flags; isolates and aborts cleanly under power control. Sits behind the issue logic in the power-managed compute domain.

Parameters:
- WIDTH, 16, operand/result width (>=4).
- MUL_CYCLES, 5, accept-to-out_valid latency of MUL (>=1).
- SHAMT_W, clog2(WIDTH), derived localparam: shift-amount bits taken from B.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_pwr_en  in  1  domain powered when high.
- iso_en  in  1  isolation request.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept.
- opcode  in  4  operation select.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  primary result (low product / quotient).
- result_hi  out  WIDTH  high product / remainder, else 0.
- flag_zero  out  1  result==0.
- flag_carry  out  1  ADD carry-out / SUB borrow.
- flag_ovf  out  1  signed overflow (ADD/SUB), MUL high half nonzero.
- flag_dz  out  1  divide by zero.
- flag_abort  out  1  sticky: operation killed by power/isolation.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE, counter 0. Outputs out_valid, result, result_hi, all flags, busy = 0. Reset beats power control and handshake; reset mid-operation discards the operation.
- Active condition: act = alu_pwr_en & !iso_en.
- in_ready = act & (state==IDLE). An accept is in_valid & in_ready at a rising edge; it latches A, B and opcode and clears flag_abort.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SHL by B[SHAMT_W-1:0]; 7 XNOR; 8 MUL (unsigned, 2*WIDTH product); 9 DIV (unsigned).
  - A SHR logical; B SRA arithmetic.
  - C-F: result 0, all flags 0, single-cycle timing.
- States: IDLE, MUL, DIV, DONE.
  - Single-cycle op: accept at edge k → state DONE, outputs loaded, out_valid=1 after edge k.
  - MUL: counter counts accept edge as 0; out_valid=1 after edge k+MUL_CYCLES.
  - DIV: restoring, one quotient bit per edge over edges k+1..k+WIDTH; out_valid=1 after edge k+WIDTH.
  - DIV with B==0: skip iteration and go to DONE after edge k with result=all ones, result_hi=A, flag_dz=1.
  - DONE: result and flags held stable while out_valid & !out_ready. On out_valid & out_ready → IDLE, out_valid=0 next edge.
- No overlap: a new accept can occur no earlier than the edge after the output handshake.
- Flags are registered with result, and valid only while out_valid=1.
  - flag_carry: 0 for ops other than ADD/SUB.
  - flag_ovf: for MUL = (result_hi != 0).
  - result_hi: 0 except MUL and DIV.
- Power/isolation: while !act, outputs in_ready, out_valid, result, result_hi, flag_zero/carry/ovf/dz are combinationally clamped to 0. busy and flag_abort are always-on and not clamped.
  - Any edge with !act and state != IDLE: state → IDLE, counter 0, out_valid register 0, flag_abort=1.
  - A pending undelivered DONE result is also discarded and sets flag_abort.
- Simultaneous events:
  - iso_en rising in the same cycle as in_valid: no accept.
  - out_ready held high in DONE: consumed on first valid cycle.
- Counter width: clog2(max(MUL_CYCLES, WIDTH)+1) bits; no wrap inside an operation.

Test Plan:
- ADD A=0xFFFF,B=0x0001 (WIDTH=16) → out_valid 1 cycle after accept, result 0x0000, zero=1, carry=1, ovf=0. SUB 0x8000-0x0001 → 0x7FFF, ovf=1, carry=0.
- MUL 0x1234*0x0100, A/B driven to 0 right after accept → out_valid exactly 5 cycles after accept, result=0x3400, result_hi=0x0012, ovf=1; in_ready=0, busy=1 throughout.
- DIV 1000/7 → out_valid 16 cycles after accept, result=142, result_hi=6. DIV 0x00AB/0 → next cycle result=0xFFFF, result_hi=0x00AB, dz=1.
- Backpressure: ADD result with out_ready=0 for 3 cycles → result/flags stable, out_valid=1, in_ready=0. Handshake on 4th cycle → IDLE, accept possible next cycle.
- iso_en=1 on 5th DIV iteration → same cycle all clamped outputs 0; next edge busy=0, flag_abort=1. After iso_en=0, OR 0x00F0|0x000F → 0x00FF, flag_abort cleared on accept.
- rst=1 mid-MUL (cycle 3) → after edge all outputs 0, state IDLE. SRA 0x8000 by 4 after reset → 0xF800.
